// File: rtl/d_ff_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : d_ff_pipe
//  Description : Parametrised register delay line. WIDTH-bit data moves
//                through DEPTH flop stages, and a valid bit travels with
//                each stage. Supports stall (en), synchronous flush, a
//                runtime tap select and an occupancy count. Optional
//                per-stage parity is enabled with D_FF_PIPE_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module d_ff_pipe #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int SEL_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic             a_vld,
    input  logic [SEL_W-1:0] tap_sel,
`ifdef D_FF_PIPE_PARITY_EN
    input  logic             par_inj,
    output logic             y_perr,
`endif
    output logic [WIDTH-1:0] y,
    output logic             y_vld,
    output logic [WIDTH-1:0] tap_y,
    output logic             tap_vld,
    output logic [CNT_W-1:0] occ
);

    // Index of the last stage, and DEPTH widened by one bit so that any
    // tap_sel value can be compared against it without truncation.
    localparam logic [SEL_W-1:0] c_last  = SEL_W'(DEPTH - 1);
    localparam logic [SEL_W:0]   c_depth = (SEL_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_stage [DEPTH];
    logic             r_vld   [DEPTH];
    logic [CNT_W-1:0] r_occ;

    logic [CNT_W-1:0] w_occ_next;
    logic [SEL_W-1:0] w_tap_idx;

    // Data/valid shift register: reset and flush clear everything, en advances.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= '0;
                r_vld[k]   <= 1'b0;
            end
            r_occ <= '0;
        end else if (en) begin
            r_stage[0] <= a;
            r_vld[0]   <= a_vld;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
                r_vld[k]   <= r_vld[k-1];
            end
            r_occ <= w_occ_next;
        end
    end

    // Occupancy tracks entries in minus entries out; both at once cancel.
    always_comb begin
        w_occ_next = r_occ;
        if (a_vld && !r_vld[DEPTH-1]) begin
            w_occ_next = r_occ + CNT_W'(1);
        end else if (!a_vld && r_vld[DEPTH-1]) begin
            w_occ_next = r_occ - CNT_W'(1);
        end
    end

    // Tap select clamps out-of-range indices to the final stage.
    always_comb begin
        w_tap_idx = tap_sel;
        if ({1'b0, tap_sel} >= c_depth) begin
            w_tap_idx = c_last;
        end
    end

    assign tap_y   = r_stage[w_tap_idx];
    assign tap_vld = r_vld[w_tap_idx];
    assign y       = r_stage[DEPTH-1];
    assign y_vld   = r_vld[DEPTH-1];
    assign occ     = r_occ;

`ifdef D_FF_PIPE_PARITY_EN
    logic r_par [DEPTH];

    // Parity column moves in lockstep with the data; par_inj corrupts it.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_par[k] <= 1'b0;
            end
        end else if (en) begin
            r_par[0] <= (^a) ^ par_inj;
            for (int k = 1; k < DEPTH; k++) begin
                r_par[k] <= r_par[k-1];
            end
        end
    end

    assign y_perr = r_vld[DEPTH-1] & ((^r_stage[DEPTH-1]) ^ r_par[DEPTH-1]);
`endif

endmodule
`default_nettype wire

// File: tb/tb_d_ff_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_d_ff_pipe
//  Description : Self-checking bench for d_ff_pipe (WIDTH=4, DEPTH=4).
//                Every captured entry is queued; the stage contents, the
//                y/tap outputs and occ are derived from that queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_d_ff_pipe;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int SEL_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic             v;
        logic             p;
        logic [WIDTH-1:0] d;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst, en, flush, a_vld, par_inj;
    logic [WIDTH-1:0] a;
    logic [SEL_W-1:0] tap_sel;
    logic [WIDTH-1:0] y, tap_y;
    logic             y_vld, tap_vld, y_perr;
    logic [CNT_W-1:0] occ;

    ent_t q[$];
    int   vec  = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    d_ff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .flush   (flush),
        .a       (a),
        .a_vld   (a_vld),
        .tap_sel (tap_sel),
`ifdef D_FF_PIPE_PARITY_EN
        .par_inj (par_inj),
        .y_perr  (y_perr),
`endif
        .y       (y),
        .y_vld   (y_vld),
        .tap_y   (tap_y),
        .tap_vld (tap_vld),
        .occ     (occ)
    );

`ifndef D_FF_PIPE_PARITY_EN
    assign y_perr = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, update the scoreboard, check all outputs.
    task automatic step(input logic s_rst, input logic s_flush, input logic s_en,
                        input logic [WIDTH-1:0] s_a, input logic s_vld,
                        input logic [SEL_W-1:0] s_sel, input logic s_inj);
        ent_t e_y, e_t;
        int   cnt, idx;
        rst = s_rst; flush = s_flush; en = s_en;
        a = s_a; a_vld = s_vld; tap_sel = s_sel; par_inj = s_inj;
        @(posedge clk);
        #1;
        if (s_rst || s_flush) begin
            q.delete();
        end else if (s_en) begin
            q.push_back('{v: s_vld, p: s_inj, d: s_a});
            if (q.size() > DEPTH) void'(q.pop_front());
        end
        e_y = '0;
        if (q.size() == DEPTH) e_y = q[0];
        idx = q.size() - 1 - int'(s_sel);
        e_t = (idx >= 0) ? q[idx] : '0;
        cnt = 0;
        foreach (q[i]) cnt += int'(q[i].v);
        chk("y",       32'(y),       32'(e_y.d));
        chk("y_vld",   32'(y_vld),   32'(e_y.v));
        chk("tap_y",   32'(tap_y),   32'(e_t.d));
        chk("tap_vld", 32'(tap_vld), 32'(e_t.v));
        chk("occ",     32'(occ),     32'(cnt));
`ifdef D_FF_PIPE_PARITY_EN
        chk("y_perr",  32'(y_perr),  32'(e_y.v & e_y.p));
`endif
    endtask

    initial begin
        logic [WIDTH-1:0] vals [4];
        // reset
        step(1, 0, 0, 4'h0, 0, 0, 0);
        step(1, 0, 1, 4'h9, 1, 2, 0);

        // streaming 3,5,9,C then 1,2,3,4 (pipe stays full, occ holds 4)
        vals = '{4'h3, 4'h5, 4'h9, 4'hC};
        for (int i = 0; i < 4; i++) step(0, 0, 1, vals[i], 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, WIDTH'(i + 1), 1, 3, 0);

        // stall 5 cycles with a=F, then resume with F
        for (int i = 0; i < 5; i++) step(0, 0, 0, 4'hF, 1, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 4'hF, 1, 2, 0);

        // flush with en=1 and a=7, 7 is dropped
        step(0, 1, 1, 4'h7, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 4'h0, 0, 0, 0);

        // bubbles with tap_sel=1
        vals = '{4'hA, 4'hB, 4'hC, 4'hD};
        for (int i = 0; i < 4; i++) step(0, 0, 1, vals[i], (i % 2) == 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 4'h0, 0, 1, 0);

        // fill, reset mid-stream with en=1, refill from 6
        for (int i = 0; i < 4; i++) step(0, 0, 1, WIDTH'(i + 8), 1, 0, 0);
        step(1, 0, 1, 4'hE, 1, 0, 0);
        step(0, 0, 1, 4'h6, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 4'h0, 0, 3, 0);

        // parity injection on a single sample
        step(0, 0, 1, 4'h5, 1, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 4'h3, 1, 0, 0);

        // random mix of stall, bubbles, taps and occasional flush
        for (int i = 0; i < 60; i++) begin
            step(0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 WIDTH'($urandom), 1'($urandom), SEL_W'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/d_ff_pipe.md
Name: d_ff_pipe

Overview:
- Parametrised register delay line: WIDTH-bit data moves through DEPTH flop stages, with a valid bit travelling alongside each stage.
- Adds what a fixed 2-stage DFF chain lacks:
  - stall (en)
  - flush
  - runtime tap select
  - occupancy count
- Used as a configurable latency-matching / pipeline-balancing element in sequential datapaths.

Parameters:
- WIDTH, 4, data width in bits (>=1)
- DEPTH, 4, number of register stages (>=2); full-path latency in enabled cycles
- SEL_W, $clog2(DEPTH), width of tap_sel (derived; do not override)
- CNT_W, $clog2(DEPTH+1), width of occ (derived; do not override)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  advance enable; 0 = stall, all stages hold
- flush  input  1  clear all stages, synchronous
- a  input  WIDTH  data in
- a_vld  input  1  data-in valid
- tap_sel  input  SEL_W  stage index for tap output
- y  output  WIDTH  data of stage DEPTH-1
- y_vld  output  1  valid of stage DEPTH-1
- tap_y  output  WIDTH  data of selected stage
- tap_vld  output  1  valid of selected stage
- occ  output  CNT_W  number of stages holding valid data

Behaviour:
- Storage: stage[0..DEPTH-1] of WIDTH bits; vld[0..DEPTH-1] of 1 bit.
- Reset: rst sampled at posedge. All stage data = 0, all vld = 0, occ = 0. Outputs y = 0, y_vld = 0, tap_y = 0, tap_vld = 0, occ = 0. rst has top priority and may occur mid-stream; in-flight data is discarded.
- Priority per edge: rst > flush > en.
- flush=1: all stage data = 0, all vld = 0, occ = 0 next cycle. a/a_vld presented that cycle are dropped.
- en=1 (no rst/flush):
  - stage[0] <= a; vld[0] <= a_vld
  - stage[k] <= stage[k-1], vld[k] <= vld[k-1] for k = 1..DEPTH-1
  - Data is captured even when a_vld = 0; bubbles propagate as vld = 0 entries.
- en=0: all stages and occ hold.
- Latency: a sample entered at edge N appears on y at edge N+DEPTH-1. This counts only enabled edges; stalled cycles add latency.
- y / y_vld: driven directly from stage[DEPTH-1] / vld[DEPTH-1]; no output register beyond the stage.
- tap_y / tap_vld: combinational mux of stage[tap_sel] / vld[tap_sel].
  - tap_sel = 0 gives stage 0, i.e. 1-cycle delay.
  - tap_sel >= DEPTH (possible when DEPTH is not a power of 2) clamps to stage DEPTH-1.
- occ: registered count, always equal to popcount of vld.
  - Update on enabled edge: occ_next = occ + a_vld - vld[DEPTH-1].
  - Simultaneous entry and exit leaves occ unchanged.
  - Range 0..DEPTH; never wraps.
- No backpressure: the output side cannot stall independently. Data leaving stage DEPTH-1 on an enabled edge is gone.

Optional Feature:
- Macro: D_FF_PIPE_PARITY_EN
- Defined:
  - Each stage carries an extra parity bit. Stage 0 stores ^a XOR par_inj, using new port par_inj (input, 1).
  - Parity bit shifts, stalls, flushes and resets (to 0) exactly like data.
  - New output y_perr (1 bit) = y_vld AND (^y != parity of stage DEPTH-1); combinational. Reset value 0.
- Undefined: par_inj and y_perr ports do not exist; no parity storage.

Test Plan:
- WIDTH=4, DEPTH=4, en=1, a_vld=1, a = 3,5,9,C on consecutive edges after reset release -> y = 3,5,9,C on edges 4..7 after first capture (latency 3 edges after entry); y_vld=1 from the first of these; occ ramps 1,2,3,4 and holds at 4.
- Stall: fill with 1,2,3,4; drive en=0 for 5 cycles with a=F -> y stays 1, occ stays 4; on en=1, y steps to 2, then 3, 4, F.
- Flush mid-stream: pipe holds 4 valid entries; flush=1 together with en=1, a=7 -> next cycle y=0, y_vld=0, occ=0; 7 never appears.
- Bubbles and tap: a_vld pattern 1,0,1,0 with a = A,B,C,D; tap_sel=1 -> tap_y shows A one cycle after stage 0 holds A, with tap_vld=1; the B slot shows tap_vld=0; occ peaks at 2.
- Reset mid-operation: rst=1 for one edge while full and en=1 -> all outputs 0 next cycle; refill from a=6 gives y=6 exactly DEPTH-1 edges after entry.
- Parity (macro defined): a=5, par_inj=1 for one sample -> y_perr=1 only in the cycle y=5, y_vld=1; with par_inj=0 everywhere, y_perr stays 0.
